log_ram_uart_dump: RTL and testbench

LOG_RAM_UART_DUMP -- requirements
Module: log_ram_uart_dump

---
 rtl/log_ram_uart_dump.sv | 157 +++++++++++++++
 tb/tb_log_ram_uart_dump.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_ram_uart_dump.sv
// Logger RAM dump over UART: reads words 0..N-1 and sends each word as
// RAM_WIDTH/8 frames (8N1), MSB byte first, with an abortable byte stream.
module log_ram_uart_dump #(
  parameter int unsigned RAM_WIDTH = 32,
  parameter int unsigned RAM_DEPTH = 32768,
  parameter int unsigned BAUD_DIV  = 868,
  localparam int unsigned AW       = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [AW:0]          i_num_words,
  input  logic                 i_abort,
  input  logic [RAM_WIDTH-1:0] i_data_ram,
  output logic                 o_en_read,
  output logic [AW-1:0]        o_read_adrs,
  output logic                 o_tx_uart,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned NB = RAM_WIDTH / 8;
  localparam int unsigned BW = $clog2(BAUD_DIV + 1);
  localparam int unsigned YW = $clog2(NB + 1);

  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(RAM_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [YW-1:0] BYTE_LAST = YW'(NB - 1);
  localparam logic [3:0]    STOP_BIT  = 4'd9;

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, FINISH} state_t;

  state_t               state, state_n;
  logic [BW-1:0]        baud_cnt, baud_n;
  logic [3:0]           bit_cnt, bit_n;     // 0 = start, 1..8 = data, 9 = stop
  logic [YW-1:0]        byte_cnt, byte_n;
  logic [RAM_WIDTH-1:0] word_sr, sr_n;
  logic [AW-1:0]        word_cnt, cnt_n;
  logic [AW:0]          word_total, total_n;
  logic [AW:0]          clamped, cnt_inc;
  logic [AW-1:0]        adrs_n;
  logic                 en_n, done_n, busy_n, tx_n;
  logic [7:0]           cur_byte;
  logic [2:0]           data_idx;

  // Next-state, counters and the next value of every registered output.
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_cnt;
    byte_n   = byte_cnt;
    sr_n     = word_sr;
    cnt_n    = word_cnt;
    total_n  = word_total;
    adrs_n   = o_read_adrs;
    en_n     = 1'b0;
    done_n   = 1'b0;
    busy_n   = o_busy;
    tx_n     = 1'b1;
    clamped  = (i_num_words > DEPTH_CNT) ? DEPTH_CNT : i_num_words;
    cnt_inc  = {1'b0, word_cnt} + (AW+1)'(1);

    case (state)
      IDLE: begin
        if (i_start && !o_busy) begin
          total_n = clamped;
          cnt_n   = '0;
          adrs_n  = '0;
          busy_n  = 1'b1;
          if (clamped == '0) begin
            state_n = FINISH;
          end else begin
            state_n = FETCH;
            en_n    = 1'b1;
          end
        end
      end
      FETCH: state_n = i_abort ? FINISH : LATCH;
      LATCH: begin
        sr_n    = i_data_ram;
        byte_n  = '0;
        bit_n   = '0;
        baud_n  = '0;
        state_n = i_abort ? FINISH : SEND;
      end
      SEND: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n = '0;
          if (bit_cnt == STOP_BIT) begin
            bit_n = '0;
            if (i_abort) begin
              state_n = FINISH;
            end else if (byte_cnt != BYTE_LAST) begin
              byte_n = byte_cnt + YW'(1);
              sr_n   = word_sr << 8;
            end else if (cnt_inc < word_total) begin
              cnt_n   = cnt_inc[AW-1:0];
              adrs_n  = cnt_inc[AW-1:0];
              en_n    = 1'b1;
              state_n = FETCH;
            end else begin
              state_n = FINISH;
            end
          end else begin
            bit_n = bit_cnt + 4'd1;
          end
        end else begin
          baud_n = baud_cnt + BW'(1);
        end
      end
      FINISH: begin
        state_n = IDLE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    // Line level is derived from the next bit position so the serial output can be a flop.
    cur_byte = sr_n[RAM_WIDTH-1 -: 8];
    data_idx = 3'(bit_n - 4'd1);
    if (state_n == SEND && bit_n != STOP_BIT)
      tx_n = (bit_n == 4'd0) ? 1'b0 : cur_byte[data_idx];
  end

  // State, datapath and output registers; reset forces the line idle at once.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      word_sr     <= '0;
      word_cnt    <= '0;
      word_total  <= '0;
      o_read_adrs <= '0;
      o_en_read   <= 1'b0;
      o_done      <= 1'b0;
      o_busy      <= 1'b0;
      o_tx_uart   <= 1'b1;
    end else begin
      state       <= state_n;
      baud_cnt    <= baud_n;
      bit_cnt     <= bit_n;
      byte_cnt    <= byte_n;
      word_sr     <= sr_n;
      word_cnt    <= cnt_n;
      word_total  <= total_n;
      o_read_adrs <= adrs_n;
      o_en_read   <= en_n;
      o_done      <= done_n;
      o_busy      <= busy_n;
      o_tx_uart   <= tx_n;
    end
  end

endmodule

// File: tb/tb_log_ram_uart_dump.sv
// Directed bench for log_ram_uart_dump: RAM model, UART decoder and
// scoreboards of expected read addresses and frames (byte + start gap).
`timescale 1ns/1ps
module tb_log_ram_uart_dump;

  localparam int unsigned RAM_WIDTH = 32;
  localparam int unsigned RAM_DEPTH = 8;
  localparam int unsigned BAUD_DIV  = 4;
  localparam int unsigned AW        = $clog2(RAM_DEPTH);

  logic                 clk = 1'b0;
  logic                 i_reset = 1'b0;
  logic                 i_start = 1'b0;
  logic                 i_abort = 1'b0;
  logic [AW:0]          i_num_words = '0;
  logic [RAM_WIDTH-1:0] i_data_ram;
  logic                 o_en_read;
  logic [AW-1:0]        o_read_adrs;
  logic                 o_tx_uart;
  logic                 o_busy;
  logic                 o_done;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } frame_t;

  frame_t         exp_frames[$];
  int             exp_adrs[$];
  logic [31:0]    ram [0:RAM_DEPTH-1];

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int read_cnt = 0;
  int frame_cnt = 0;
  int t_start = 0;
  int prev_frame = 0;

  bit         rx_active = 1'b0;
  int         rx_pos = 0;
  int         rx_start = 0;
  logic [7:0] rx_byte = '0;
  logic       rx_start_bit = 1'b0;

  log_ram_uart_dump #(
    .RAM_WIDTH (RAM_WIDTH),
    .RAM_DEPTH (RAM_DEPTH),
    .BAUD_DIV  (BAUD_DIV)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_num_words (i_num_words),
    .i_abort     (i_abort),
    .i_data_ram  (i_data_ram),
    .o_en_read   (o_en_read),
    .o_read_adrs (o_read_adrs),
    .o_tx_uart   (o_tx_uart),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM with one cycle of read latency
  always @(posedge clk) if (o_en_read) i_data_ram <= ram[o_read_adrs];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // read address scoreboard
  always @(negedge clk) begin
    if (i_reset === 1'b1 && o_en_read === 1'b1) begin
      read_cnt++;
      check("read_expected", 32'(exp_adrs.size() != 0), 1);
      if (exp_adrs.size() != 0) check("read_adrs", 32'(o_read_adrs), 32'(exp_adrs.pop_front()));
    end
  end

  // done pulse monitor
  always @(negedge clk) begin
    if (o_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_low_at_done", 32'(o_busy), 0);
    end
  end

  // UART decoder: samples each bit in its middle (BAUD_DIV = 4)
  always @(negedge clk) begin : rx_dec
    frame_t f;
    if (i_reset !== 1'b1) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (o_tx_uart === 1'b0) begin
        rx_active = 1'b1;
        rx_pos    = 0;
        rx_start  = cyc;
      end
    end else begin
      rx_pos++;
      if (rx_pos == 2) begin
        rx_start_bit = o_tx_uart;
      end else if (rx_pos >= 6 && rx_pos <= 34 && (rx_pos % 4) == 2) begin
        rx_byte[(rx_pos - 6) / 4] = o_tx_uart;
      end else if (rx_pos == 38) begin
        rx_active = 1'b0;
        frame_cnt++;
        check("start_bit", 32'(rx_start_bit), 0);
        check("stop_bit", 32'(o_tx_uart), 1);
        check("busy_in_frame", 32'(o_busy), 1);
        check("frame_expected", 32'(exp_frames.size() != 0), 1);
        if (exp_frames.size() != 0) begin
          f = exp_frames.pop_front();
          check("frame_byte", 32'(rx_byte), 32'(f.data));
          check("frame_gap", 32'(rx_start - prev_frame), 32'(f.gap));
        end
        prev_frame = rx_start;
      end
    end
  end

  // First frame of a dump starts 3 cycles after i_start is raised; 40 between frames, 42 between words.
  task automatic push_word(input int adrs, input logic [31:0] w, input int nbytes, input bit first);
    frame_t f;
    exp_adrs.push_back(adrs);
    for (int b = 0; b < nbytes; b++) begin
      f.data = w[31 - 8*b -: 8];
      f.gap  = (b != 0) ? 40 : (first ? 3 : 42);
      exp_frames.push_back(f);
    end
  endtask

  task automatic pulse_start(input logic [AW:0] n);
    @(negedge clk);
    i_num_words = n;
    i_start     = 1'b1;
    t_start     = cyc;
    prev_frame  = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int k = 0;
    while (o_done !== 1'b1 && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, 32'(o_done === 1'b1), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic finish_checks(input string tag, input int d0, input int latency);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 1);
    check({tag, "_done_latency"}, 32'(done_cyc - t_start), 32'(latency));
    check({tag, "_frames_left"}, 32'(exp_frames.size()), 0);
    check({tag, "_reads_left"}, 32'(exp_adrs.size()), 0);
    check({tag, "_busy_idle"}, 32'(o_busy), 0);
    check({tag, "_tx_idle"}, 32'(o_tx_uart), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, r0, f0, k;
    for (int a = 0; a < RAM_DEPTH; a++) ram[a] = '0;

    // reset values while reset is held
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(o_tx_uart), 1);
    check("rst_en_read", 32'(o_en_read), 0);
    check("rst_adrs", 32'(o_read_adrs), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);

    // single word, start raised together with reset release
    ram[0] = 32'hA5C3_0F81;
    push_word(0, ram[0], 4, 1'b1);
    d0 = done_cnt;
    @(negedge clk);
    i_reset     = 1'b1;
    i_num_words = 1;
    i_start     = 1'b1;
    t_start     = cyc;
    prev_frame  = cyc;
    @(negedge clk);
    i_start = 1'b0;
    check("single_busy_after_start", 32'(o_busy), 1);
    wait_done("single", 400);
    finish_checks("single", d0, 164);

    // three words, RAM[k] = k
    for (int a = 0; a < 3; a++) begin
      ram[a] = 32'(a);
      push_word(a, ram[a], 4, a == 0);
    end
    d0 = done_cnt;
    pulse_start(3);
    wait_done("three", 1000);
    finish_checks("three", d0, 488);

    // zero words: no read, no frame
    d0 = done_cnt;
    r0 = read_cnt;
    f0 = frame_cnt;
    pulse_start(0);
    wait_done("zero", 50);
    finish_checks("zero", d0, 2);
    check("zero_no_read", 32'(read_cnt - r0), 0);
    check("zero_no_frame", 32'(frame_cnt - f0), 0);

    // start held high for the whole dump, count input changed after acceptance
    for (int a = 0; a < 3; a++) push_word(a, ram[a], 4, a == 0);
    d0 = done_cnt;
    @(negedge clk);
    i_num_words = 3;
    i_start     = 1'b1;
    t_start     = cyc;
    prev_frame  = cyc;
    @(negedge clk);
    i_num_words = 1;
    k = 0;
    while (o_done !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    i_start = 1'b0;
    check("held_done_seen", 32'(o_done === 1'b1), 1);
    repeat (4) @(negedge clk);
    finish_checks("held", d0, 488);

    // abort in the middle of a data bit of byte 2 of word 0
    ram[0] = 32'h1122_3344;
    ram[1] = 32'h5566_7788;
    ram[2] = 32'h99AA_BBCC;
    ram[3] = 32'hDDEE_FF00;
    push_word(0, ram[0], 3, 1'b1);
    d0 = done_cnt;
    pulse_start(4);
    while (cyc < t_start + 98) @(negedge clk);
    i_abort = 1'b1;
    wait_done("abort", 200);
    i_abort = 1'b0;
    finish_checks("abort", d0, 124);

    // count above depth is clamped to RAM_DEPTH
    for (int a = 0; a < RAM_DEPTH; a++) begin
      ram[a] = 32'h1111_1111 * a + 32'h0000_000F;
      push_word(a, ram[a], 4, a == 0);
    end
    d0 = done_cnt;
    pulse_start(10);
    wait_done("clamp", 3000);
    finish_checks("clamp", d0, 1298);

    // reset during a low data bit, then a clean dump
    ram[0] = '0;
    ram[1] = '0;
    push_word(0, ram[0], 0, 1'b1);
    pulse_start(2);
    while (cyc < t_start + 12) @(negedge clk);
    check("tx_low_before_reset", 32'(o_tx_uart), 0);
    @(posedge clk);
    #2;
    i_reset = 1'b0;
    #1;
    check("midrst_tx", 32'(o_tx_uart), 1);
    check("midrst_en_read", 32'(o_en_read), 0);
    check("midrst_adrs", 32'(o_read_adrs), 0);
    check("midrst_busy", 32'(o_busy), 0);
    check("midrst_done", 32'(o_done), 0);
    check("midrst_read_issued", 32'(exp_adrs.size()), 0);
    exp_frames.delete();
    repeat (3) @(negedge clk);
    check("midrst_tx_held", 32'(o_tx_uart), 1);
    ram[0] = 32'hDEAD_BEEF;
    push_word(0, ram[0], 4, 1'b1);
    d0 = done_cnt;
    @(negedge clk);
    i_reset     = 1'b1;
    i_num_words = 1;
    i_start     = 1'b1;
    t_start     = cyc;
    prev_frame  = cyc;
    @(negedge clk);
    i_start = 1'b0;
    check("after_rst_busy", 32'(o_busy), 1);
    wait_done("after_rst", 400);
    finish_checks("after_rst", d0, 164);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
